// File: rtl/posit_add_arbiter.sv
// posit_add_arbiter
//   Shares one pipelined posit adder among NREQ requesters. A round-robin
//   arbiter grants one requester per cycle. The adder operands go out in
//   the grant cycle. A LAT-stage tag pipe follows each operation through the
//   adder. When a result reaches the end of the tag pipe it is written with
//   its requester id into an in-order response FIFO. Grants are limited by
//   credit, so the FIFO always has room for every result in flight.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   req_valid  per-requester operand valid                [NREQ]
//   req_a/b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  per-requester accept, one-hot or zero      [NREQ]
//   add_a/b    operands to the shared adder (0 when idle) [WIDTH]
//   add_q      adder result, valid LAT edges after issue  [WIDTH]
//   rsp_valid  response FIFO non-empty
//   rsp_id     requester index of the head response
//   rsp_q      head response sum
//   rsp_ready  consumer accepts the head response
//   busy       anything in the tag pipe or the FIFO
module posit_add_arbiter #(
    parameter int WIDTH = 7,
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int DEPTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic [WIDTH-1:0]        add_q,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_q,
    input  logic                    rsp_ready,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    logic [IDW-1:0]       last_grant_r;
    logic [LAT-1:0]       tag_valid_r;
    logic [IDW-1:0]       tag_id_r [LAT];
    logic [IDW+WIDTH-1:0] fifo_mem_r [DEPTH];
    logic [PW-1:0]        rd_ptr_r;
    logic [PW-1:0]        wr_ptr_r;
    logic [CW-1:0]        count_r;

    logic                 grant_found_s;
    logic [IDW-1:0]       grant_id_s;
    logic                 credit_ok_s;
    logic                 grant_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 nonempty_s;
    logic [IDW+WIDTH-1:0] head_s;
    int                   occ_s;

    // FIFO pointer advance with wrap at DEPTH, so DEPTH need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Round-robin search starting one past the last grant and wrapping
    always_comb begin
        logic [IDW:0] cand;
        cand          = '0;
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant_r} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end else begin
                cand = cand;
            end
            if (!grant_found_s && req_valid[cand[IDW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand[IDW-1:0];
            end else begin
                grant_id_s    = grant_id_s;
            end
        end
    end

    // Credit uses occupancy at cycle start. A pop in this cycle frees a slot only from the next cycle.
    always_comb begin
        occ_s = int'(count_r);
        for (int k = 0; k < LAT; k++) begin
            if (tag_valid_r[k]) begin
                occ_s = occ_s + 1;
            end else begin
                occ_s = occ_s;
            end
        end
        credit_ok_s = (occ_s < DEPTH);
    end

    // Grant decode and operand mux; everything is forced idle while in reset
    always_comb begin
        grant_s   = rst & grant_found_s & credit_ok_s;
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s && (grant_id_s == IDW'(i))) begin
                req_ready[i] = 1'b1;
                add_a        = req_a[i*WIDTH +: WIDTH];
                add_b        = req_b[i*WIDTH +: WIDTH];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    assign nonempty_s = (count_r != '0);
    assign push_s     = tag_valid_r[LAT-1];
    assign rsp_valid  = rst & nonempty_s;
    assign pop_s      = rsp_valid & rsp_ready;
    assign busy       = rst & ((|tag_valid_r) | nonempty_s);
    assign head_s     = fifo_mem_r[rd_ptr_r];
    assign rsp_id     = head_s[IDW+WIDTH-1:WIDTH];
    assign rsp_q      = head_s[WIDTH-1:0];

    // Arbiter state, tag pipe and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_r <= IDW'(NREQ - 1);
            tag_valid_r  <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id_r[k] <= '0;
            end
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
        end else begin
            if (grant_s) begin
                last_grant_r <= grant_id_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
            tag_valid_r[0] <= grant_s;
            tag_id_r[0]    <= grant_id_s;
            for (int k = 1; k < LAT; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_id_r[k]    <= tag_id_r[k-1];
            end
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response storage; the credit rule guarantees a free slot on every push
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {tag_id_r[LAT-1], add_q};
        end
    end

endmodule
